uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Shares one UART serial transmitter between NUM_REQUESTERS byte sources.
- Arbitrates round-robin, with packet locking.
- Hands one byte at a time to the transmitter via a start/busy handshake.
- Generates the baud-rate tick enable that paces the transmitter and the receiver.
- Sits between the on-chip byte producers and the transmitter/receiver pair.

Parameters:
- NUM_REQUESTERS, 4, number of byte sources; range 2..8.
- CLOCKS_PER_BIT, 868, system clocks per serial bit (100 MHz / 115200); must be ≥ 2.
- LOCK_TIMEOUT, 1024, cycles a locked requester may stay invalid before its lock is dropped.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  reset.
- request_valid  in  NUM_REQUESTERS  per-requester byte valid.
- request_data  in  8*NUM_REQUESTERS  per-requester byte; requester i uses bits [8i+7:8i].
- request_last  in  NUM_REQUESTERS  byte is the last of a packet; sampled with data.
- request_ready  out  NUM_REQUESTERS  one-hot accept strobe; a transfer occurs when valid and ready are both high.
- grant_index  out  clog2(NUM_REQUESTERS)  index of the current or most recent grantee.
- tx_start  out  1  one-cycle pulse that launches the transmitter.
- tx_data  out  8  byte for the transmitter; held from tx_start until the next tx_start.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start and falls after the stop bit.
- baud_tick  out  1  one-cycle bit-rate enable.

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (reset_n low at a clock edge, including mid-byte):
  - request_ready=0, tx_start=0, tx_data=0, grant_index=0, baud_tick=0.
  - Round-robin pointer = NUM_REQUESTERS-1, so requester 0 wins first.
  - Lock cleared, baud counter=0, state=IDLE.
  - A byte already in the transmitter is abandoned; no handshake is replayed after reset.
- Baud generator:
  - Counter runs 0..CLOCKS_PER_BIT-1 and wraps.
  - baud_tick=1 on the cycle the counter equals CLOCKS_PER_BIT-1.
  - Counter is forced to 0 on any cycle where tx_start=1, aligning the bit boundaries to the start bit.
  - Free-running in every state.
- State machine:
  - IDLE:
    - If the lock is set and the locked requester is valid: go to ISSUE with that requester.
    - Else if any request_valid is set: pick the first valid index after the pointer (modulo N), store it in grant_index, go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - tx_start=1, tx_data=request_data of the grantee, request_ready[grantee]=1.
    - Pointer = grantee.
    - Lock = !request_last[grantee].
    - Go to WAIT_ACK.
  - WAIT_ACK (1 cycle): go to WAIT_DONE. tx_busy is ignored in this cycle.
  - WAIT_DONE: stay while tx_busy=1. On tx_busy=0, go to IDLE, or to GAP under the optional feature.
- Latency: IDLE with a valid request → tx_start two cycles later (IDLE decision, then the ISSUE cycle).
- Throughput: at most one byte per transmitter frame.
- Lock rules:
  - While the lock is set, other requesters are never granted.
  - A lock timeout counter increments each cycle the state is IDLE, the lock is set and the locked requester is invalid.
  - At LOCK_TIMEOUT the lock clears and normal arbitration resumes the same cycle.
  - The counter clears on every ISSUE.
- Simultaneous events:
  - Valid deasserted in the IDLE decision cycle: that requester is still granted in ISSUE. Requesters must hold valid until ready, so this is a protocol violation; the block does not check for it.
  - A pointer wrap from N-1 to 0 is seamless.
- request_ready is never asserted outside ISSUE.
- request_ready and tx_start are coincident.

Optional Feature:
- UART_TX_SCHED_GAP_EN defined:
  - Adds a GAP state after WAIT_DONE.
  - Holds off the next ISSUE for 2 full baud_tick periods: count 2 baud_tick pulses, then go to IDLE.
  - Gives the far-end receiver extra stop-bit margin.
- Undefined: WAIT_DONE goes directly to IDLE and no gap logic is instantiated.

Test Plan:
1. Reset, then requester 2 valid with data 0x5A, last=1 → tx_start two cycles later with tx_data=0x5A, request_ready=4'b0100 on the same cycle, grant_index=2.
2. All 4 requesters valid with last=1 continuously → grant order 0,1,2,3,0; exactly one tx_start per tx_busy fall.
3. Requester 1 sends a 3-byte packet (last only on byte 3) while requester 0 is always valid → bytes 1a,1b,1c are issued back-to-back before any requester 0 grant.
4. Requester 1 locks, then drops valid for LOCK_TIMEOUT cycles while requester 3 is valid → the lock is released and requester 3 is granted within LOCK_TIMEOUT+3 cycles.
5. CLOCKS_PER_BIT=4 → baud_tick asserted every 4th cycle; tx_start in the middle of a period restarts the count, so the next tick comes 4 cycles after tx_start.
6. reset_n low during WAIT_DONE with tx_busy high → the next cycle shows all outputs 0 and state IDLE; the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester-side bundle of the UART transmit scheduler.
// master = byte producers (valid/data/last), slave = scheduler (ready/grant).
interface uart_tx_scheduler_if #(
   parameter int NUM_REQUESTERS = 4
);
   localparam int IW = $clog2(NUM_REQUESTERS);

   logic [NUM_REQUESTERS-1:0]   request_valid;
   logic [8*NUM_REQUESTERS-1:0] request_data;
   logic [NUM_REQUESTERS-1:0]   request_last;
   logic [NUM_REQUESTERS-1:0]   request_ready;
   logic [IW-1:0]               grant_index;

   modport master (
      output request_valid,
      output request_data,
      output request_last,
      input  request_ready,
      input  grant_index
   );

   modport slave (
      input  request_valid,
      input  request_data,
      input  request_last,
      output request_ready,
      output grant_index
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin, packet-locking arbiter that feeds one UART
// transmitter a byte at a time, plus the shared baud-rate tick.
// Ports: clock, reset_n (sync, active-low), req (uart_tx_scheduler_if.slave:
// request_valid/data/last in, request_ready/grant_index out), tx_start,
// tx_data, tx_busy (transmitter handshake), baud_tick (bit-rate enable).
// Option: UART_TX_SCHED_GAP_EN inserts a 2-baud-tick gap after each frame.
module uart_tx_scheduler #(
   parameter int NUM_REQUESTERS = 4,
   parameter int CLOCKS_PER_BIT = 868,
   parameter int LOCK_TIMEOUT   = 1024
) (
   input  logic                clock,
   input  logic                reset_n,
   uart_tx_scheduler_if.slave  req,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   input  logic                tx_busy,
   output logic                baud_tick
);
   localparam int N  = NUM_REQUESTERS;
   localparam int IW = $clog2(N);
   localparam int BW = $clog2(CLOCKS_PER_BIT);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_ACK, WAIT_DONE
`ifdef UART_TX_SCHED_GAP_EN
      , GAP
`endif
   } state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] grant;
   logic          lock;
   logic [TW-1:0] to_cnt;
   logic [N-1:0]  ready;
   logic [BW-1:0] baud_count;
`ifdef UART_TX_SCHED_GAP_EN
   logic          gap_cnt;
`endif

   assign req.request_ready = ready;
   assign req.grant_index   = grant;

   // Baud generator; a launch restarts the period so bit
   // boundaries line up with the start bit.
   assign baud_tick = (baud_count == BAUD_LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         baud_count <= '0;
      end else if (tx_start || baud_tick) begin
         baud_count <= '0;
      end else begin
         baud_count <= baud_count + 1'b1;
      end
   end

   // First valid requester after the pointer; scanning from the
   // far end lets the nearest one overwrite the pick.
   logic [IW-1:0] rr_pick;
   logic          rr_any;
   int            k;

   always_comb begin
      rr_pick = '0;
      rr_any  = 1'b0;
      k       = 0;
      for (int i = N; i >= 1; i--) begin
         k = (int'(ptr) + i) % N;
         if (req.request_valid[k]) begin
            rr_pick = IW'(k);
            rr_any  = 1'b1;
         end
      end
   end

   // ptr doubles as the locked requester: it is the last grantee.
   logic locked_valid;
   logic lock_hold;

   assign locked_valid = lock && req.request_valid[ptr];
   assign lock_hold    = lock && !req.request_valid[ptr] &&
                         (to_cnt != TO_LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         ptr      <= IW'(N - 1);
         grant    <= '0;
         lock     <= 1'b0;
         to_cnt   <= '0;
         ready    <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
`ifdef UART_TX_SCHED_GAP_EN
         gap_cnt  <= 1'b0;
`endif
      end else begin
         tx_start <= 1'b0;
         ready    <= '0;
         unique case (state)
            IDLE: begin
               if (locked_valid) begin
                  grant <= ptr;
                  state <= ISSUE;
               end else if (lock_hold) begin
                  to_cnt <= to_cnt + 1'b1;
               end else begin
                  // Lock (if any) expires here; arbitrate this cycle.
                  lock   <= 1'b0;
                  to_cnt <= '0;
                  if (rr_any) begin
                     grant <= rr_pick;
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               tx_start <= 1'b1;
               tx_data  <= req.request_data[8*int'(grant) +: 8];
               ready    <= N'(1) << grant;
               ptr      <= grant;
               lock     <= !req.request_last[grant];
               to_cnt   <= '0;
               state    <= WAIT_ACK;
            end
            WAIT_ACK: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
`ifdef UART_TX_SCHED_GAP_EN
                  gap_cnt <= 1'b0;
                  state   <= GAP;
`else
                  state   <= IDLE;
`endif
               end
            end
`ifdef UART_TX_SCHED_GAP_EN
            GAP: begin
               if (baud_tick) begin
                  if (gap_cnt) begin
                     state <= IDLE;
                  end else begin
                     gap_cnt <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench for uart_tx_scheduler with
// a byte-source model per requester and a simple busy-pulse transmitter.
module tb_uart_tx_scheduler;
   localparam int N        = 4;
   localparam int CPB      = 4;
   localparam int LT       = 16;
   localparam int BUSY_LEN = 6;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy = 1'b0;
   logic       baud_tick;

   always #5 clock = ~clock;

   uart_tx_scheduler_if #(.NUM_REQUESTERS(N)) bus ();

   uart_tx_scheduler #(
      .NUM_REQUESTERS(N),
      .CLOCKS_PER_BIT(CPB),
      .LOCK_TIMEOUT(LT)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .req(bus),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .tx_busy(tx_busy),
      .baud_tick(baud_tick)
   );

   logic [8:0]   mem [N][8];
   int           head [N];
   int           tail [N];
   logic [N-1:0] hold;
   logic [N-1:0] hs;
   bit           saw_start;
   int           busy_left;
   int           cyc;
   int           tick_count;
   bit           prev_ok;
   int           prev_tick;
   bit           pend_ok;
   int           pend;
   int           ev_c [$];
   int           ev_g [$];
   int           ev_d [$];
   int           ev_r [$];
   int           n_total;
   int           n_pass;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ev(int sel, int i);
      if (i >= ev_c.size()) return 32'hFFFF_FFFF;
      case (sel)
         0:       return 32'(ev_c[i]);
         1:       return 32'(ev_g[i]);
         2:       return 32'(ev_d[i]);
         default: return 32'(ev_r[i]);
      endcase
   endfunction

   task automatic drive();
      logic [N-1:0]   v;
      logic [N-1:0]   l;
      logic [8*N-1:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
         if (head[i] < tail[i] && !hold[i]) begin
            v[i]       = 1'b1;
            d[8*i +: 8] = mem[i][head[i]][7:0];
            l[i]       = mem[i][head[i]][8];
         end
      end
      bus.request_valid = v;
      bus.request_data  = d;
      bus.request_last  = l;
   endtask

   task automatic push(int i, logic [7:0] d, logic last);
      mem[i][tail[i]] = {last, d};
      tail[i]++;
   endtask

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      hold = '0;
      ev_c.delete();
      ev_g.delete();
      ev_d.delete();
      ev_r.delete();
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) head[i]++;
      end
      if (saw_start) begin
         tx_busy   = 1'b1;
         busy_left = BUSY_LEN;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) tx_busy = 1'b0;
      end
      cyc++;
      drive();
      @(negedge clock);
      hs        = bus.request_valid & bus.request_ready;
      saw_start = tx_start;
      if (tx_start) begin
         ev_c.push_back(cyc);
         ev_g.push_back(int'(bus.grant_index));
         ev_d.push_back(int'(tx_data));
         ev_r.push_back(int'(bus.request_ready));
      end
      if (baud_tick) begin
         tick_count++;
         if (pend_ok) begin
            check("tick_after_start", 32'(cyc - pend), CPB);
            pend_ok = 1'b0;
         end else if (prev_ok) begin
            check("tick_period", 32'(cyc - prev_tick), CPB);
         end
         prev_ok   = 1'b1;
         prev_tick = cyc;
      end
      if (tx_start) begin
         pend_ok = 1'b1;
         pend    = cyc;
      end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      check("rst_ready", 32'(bus.request_ready), 0);
      check("rst_start", 32'(tx_start), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_grant", 32'(bus.grant_index), 0);
      check("rst_tick", 32'(baud_tick), 0);
      reset_n  = 1'b1;
      prev_ok  = 1'b0;
      pend_ok  = 1'b0;
      tick();
   endtask

   int t0;
   int dlt;
   int tc0;
   int t2_g [5];
   int t2_d [5];
   int t3_g [5];
   int t3_d [5];

   initial begin
      n_total    = 0;
      n_pass     = 0;
      cyc        = 0;
      tick_count = 0;
      busy_left  = 0;
      saw_start  = 1'b0;
      hs         = '0;
      prev_ok    = 1'b0;
      pend_ok    = 1'b0;
      clear_src();
      drive();

      // 1: single request, latency and handshake
      do_reset();
      clear_src();
      push(2, 8'h5A, 1'b1);
      t0 = cyc + 1;
      run(3);
      check("t1_count", 32'(ev_c.size()), 1);
      check("t1_latency", ev(0, 0) - 32'(t0), 2);
      check("t1_data", ev(2, 0), 32'h5A);
      check("t1_ready", ev(3, 0), 32'b0100);
      check("t1_grant", ev(1, 0), 2);
      run(12);

      // 2: all valid, round-robin order and frame spacing
      do_reset();
      clear_src();
      t2_g = '{0, 1, 2, 3, 0};
      t2_d = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
      push(0, 8'hA0, 1'b1);
      push(0, 8'hA1, 1'b1);
      push(1, 8'hB0, 1'b1);
      push(2, 8'hC0, 1'b1);
      push(3, 8'hD0, 1'b1);
      run(60);
      check("t2_count", 32'(ev_c.size()), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t2_grant%0d", i), ev(1, i), 32'(t2_g[i]));
         check($sformatf("t2_data%0d", i), ev(2, i), 32'(t2_d[i]));
         check($sformatf("t2_ready%0d", i), ev(3, i), 32'(1) << t2_g[i]);
         if (i > 0) begin
            check($sformatf("t2_space%0d", i), ev(0, i) - ev(0, i - 1), 10);
         end
      end

      // 3: packet lock keeps requester 1 ahead of requester 0
      do_reset();
      clear_src();
      t3_g = '{1, 1, 1, 0, 0};
      t3_d = '{8'h11, 8'h12, 8'h13, 8'h01, 8'h02};
      push(1, 8'h11, 1'b0);
      push(1, 8'h12, 1'b0);
      push(1, 8'h13, 1'b1);
      run(1);
      push(0, 8'h01, 1'b1);
      push(0, 8'h02, 1'b1);
      run(70);
      check("t3_count", 32'(ev_c.size()), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_grant%0d", i), ev(1, i), 32'(t3_g[i]));
         check($sformatf("t3_data%0d", i), ev(2, i), 32'(t3_d[i]));
      end

      // 4: lock timeout releases to requester 3
      do_reset();
      clear_src();
      push(1, 8'h21, 1'b0);
      push(1, 8'h22, 1'b1);
      run(3);
      hold[1] = 1'b1;
      push(3, 8'h31, 1'b1);
      run(60);
      hold[1] = 1'b0;
      run(30);
      check("t4_count", 32'(ev_c.size()), 3);
      check("t4_grant0", ev(1, 0), 1);
      check("t4_data0", ev(2, 0), 32'h21);
      check("t4_grant1", ev(1, 1), 3);
      check("t4_data1", ev(2, 1), 32'h31);
      dlt = int'(ev(0, 1) - ev(0, 0));
      check("t4_lock_held", 32'(dlt >= 8 + LT), 1);
      check("t4_lock_freed", 32'(dlt <= 8 + LT + 3), 1);
      check("t4_grant2", ev(1, 2), 1);
      check("t4_data2", ev(2, 2), 32'h22);

      // 5: free-running baud tick while quiet
      tc0 = tick_count;
      run(40);
      check("t5_tick_count", 32'(tick_count - tc0), 40 / CPB);

      // 6: reset in WAIT_DONE abandons the lock and the byte
      clear_src();
      push(2, 8'h61, 1'b0);
      run(3);
      check("t6_pre_grant", ev(1, 0), 2);
      run(2);
      check("t6_busy", 32'(tx_busy), 1);
      push(0, 8'h71, 1'b1);
      push(2, 8'h62, 1'b1);
      ev_c.delete();
      ev_g.delete();
      ev_d.delete();
      ev_r.delete();
      do_reset();
      run(40);
      check("t6_count", 32'(ev_c.size()), 2);
      check("t6_grant0", ev(1, 0), 0);
      check("t6_data0", ev(2, 0), 32'h71);
      check("t6_grant1", ev(1, 1), 2);
      check("t6_data1", ev(2, 1), 32'h62);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
